// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB encodings, response codes, mux select width and
//                default-slave state type for the interconnect decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Width of the data-phase slave index driven to the read-data mux
    localparam int SEL_W = 2;

    // Default-slave response state
    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_default_slave
//  Description : Responds to transfers that hit no mapped slave. Active
//                (NONSEQ/SEQ) transfers get the two-cycle ERROR response;
//                IDLE/BUSY transfers get a zero-wait OKAY.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hready,
    input  logic       hsel_def,
    input  logic [1:0] htrans,
    output logic       def_hreadyout,
    output logic       def_hresp
);

    ds_state_t r_state;
    ds_state_t w_next;
    logic      w_accept_err;

    // Only the "active transfer" bit of htrans matters for the error decision
    logic w_unused_htrans;
    assign w_unused_htrans = htrans[0];

    // An active transfer to an unmapped address is accepted this cycle
    assign w_accept_err = hready & hsel_def & htrans[1];

    // State register
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and response outputs
    always_comb begin
        w_next        = r_state;
        def_hreadyout = 1'b1;
        def_hresp     = HRESP_OKAY;
        case (r_state)
            DS_IDLE: begin
                if (w_accept_err) begin
                    w_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                def_hreadyout = 1'b0;
                def_hresp     = HRESP_ERROR;
                w_next        = DS_ERR2;
            end
            DS_ERR2: begin
                def_hreadyout = 1'b1;
                def_hresp     = HRESP_ERROR;
                // A misbehaving master may issue another unmapped transfer here
                w_next        = w_accept_err ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                w_next = DS_IDLE;
            end
        endcase
    end

endmodule : ahb_default_slave
`default_nettype wire

// File: rtl/ahb_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_decoder
//  Description : Address-phase decoder producing one-hot slave selects, the
//                registered data-phase mux select, and the system
//                hready/hresp with default-slave override for unmapped space.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_decoder
    import ahb_pkg::*;
#(
    parameter logic [3:0] REGION_1 = 4'h0,
    parameter logic [3:0] REGION_2 = 4'h1,
    parameter logic [3:0] REGION_3 = 4'h2,
    parameter logic [3:0] REGION_4 = 4'h3
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic [31:0]      haddr,
    input  logic [1:0]       htrans,
    input  logic             mux_hreadyout,
    input  logic             mux_hresp,
    output logic             hsel_1,
    output logic             hsel_2,
    output logic             hsel_3,
    output logic             hsel_4,
    output logic [SEL_W-1:0] sel,
    output logic             hready,
    output logic             hresp
);

    logic [3:0]       w_region;
    logic             w_hit;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] r_sel;
    logic             r_def_q;
    logic             w_def_hreadyout;
    logic             w_def_hresp;

    // Only the region nibble takes part in decoding
    logic [27:0] w_unused_addr;
    assign w_unused_addr = haddr[27:0];

    assign w_region = haddr[31:28];

    // Priority decode: on overlapping regions the lowest slave index wins
    always_comb begin
        hsel_1 = 1'b0;
        hsel_2 = 1'b0;
        hsel_3 = 1'b0;
        hsel_4 = 1'b0;
        w_hit  = 1'b1;
        w_idx  = '0;
        if (w_region == REGION_1) begin
            hsel_1 = 1'b1;
            w_idx  = 2'd0;
        end else if (w_region == REGION_2) begin
            hsel_2 = 1'b1;
            w_idx  = 2'd1;
        end else if (w_region == REGION_3) begin
            hsel_3 = 1'b1;
            w_idx  = 2'd2;
        end else if (w_region == REGION_4) begin
            hsel_4 = 1'b1;
            w_idx  = 2'd3;
        end else begin
            w_hit  = 1'b0;
        end
    end

    // Data-phase registers advance only on accepting cycles; a miss keeps sel
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_sel   <= '0;
            r_def_q <= 1'b0;
        end else if (hready) begin
            r_def_q <= ~w_hit;
            if (w_hit) begin
                r_sel <= w_idx;
            end
        end
    end

    assign sel = r_sel;

    ahb_default_slave u_default_slave (
        .hclk          (hclk),
        .hreset        (hreset),
        .hready        (hready),
        .hsel_def      (~w_hit),
        .htrans        (htrans),
        .def_hreadyout (w_def_hreadyout),
        .def_hresp     (w_def_hresp)
    );

    // System response: default slave owns the data phase after a miss
    always_comb begin
        hready = mux_hreadyout;
        hresp  = mux_hresp;
        if (r_def_q) begin
            hready = w_def_hreadyout;
            hresp  = w_def_hresp;
        end
    end

endmodule : ahb_decoder
`default_nettype wire

// File: tb/tb_ahb_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_decoder
//  Description : Scoreboard bench for ahb_decoder with a transaction-level
//                reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_decoder;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        mux_hreadyout;
    logic        mux_hresp;
    logic        hsel_1, hsel_2, hsel_3, hsel_4;
    logic [1:0]  sel;
    logic        hready;
    logic        hresp;

    always #5 hclk = ~hclk;

    ahb_decoder dut (
        .hclk          (hclk),
        .hreset        (hreset),
        .haddr         (haddr),
        .htrans        (htrans),
        .mux_hreadyout (mux_hreadyout),
        .mux_hresp     (mux_hresp),
        .hsel_1        (hsel_1),
        .hsel_2        (hsel_2),
        .hsel_3        (hsel_3),
        .hsel_4        (hsel_4),
        .sel           (sel),
        .hready        (hready),
        .hresp         (hresp)
    );

    typedef struct packed {
        logic [3:0] hsel;
        logic [1:0] sel;
        logic       hready;
        logic       hresp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Address map as a table: slave k owns nibble regions[k]
    logic [3:0] regions [4];
    initial begin
        regions[0] = 4'h0;
        regions[1] = 4'h1;
        regions[2] = 4'h2;
        regions[3] = 4'h3;
    end

    // Reference model state: last selected slave, whether the data phase
    // belongs to the default slave, and which error cycle (0 none, 1, 2)
    int   m_sel;
    bit   m_def;
    int   m_err;
    // What happened in the previous cycle (applied at the edge)
    bit          p_rst;
    logic [31:0] p_addr;
    logic [1:0]  p_trans;
    bit          p_hready;

    function automatic int lookup(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a[31:28] == regions[i]) return i;
        end
        return -1;
    endfunction

    // One bus cycle: advance model across the edge, drive inputs, predict
    task automatic step(input logic [31:0] a, input logic [1:0] t,
                        input logic mrdy, input logic mresp, input logic rst);
        int   pidx;
        int   idx;
        exp_t e;
        @(posedge hclk);
        #1;
        if (p_rst) begin
            m_sel = 0;
            m_def = 0;
            m_err = 0;
        end else begin
            pidx = lookup(p_addr);
            if (m_err == 1)                             m_err = 2;
            else if (p_hready && pidx < 0 && p_trans[1]) m_err = 1;
            else                                        m_err = 0;
            if (p_hready) begin
                m_def = (pidx < 0);
                if (pidx >= 0) m_sel = pidx;
            end
        end
        hreset        = rst;
        haddr         = a;
        htrans        = t;
        mux_hreadyout = mrdy;
        mux_hresp     = mresp;
        idx    = lookup(a);
        e.hsel = (idx >= 0) ? (4'b0001 << idx) : 4'b0000;
        e.sel  = m_sel[1:0];
        if (!m_def) begin
            e.hready = mrdy;
            e.hresp  = mresp;
        end else begin
            e.hready = (m_err != 1);
            e.hresp  = (m_err != 0);
        end
        q.push_back(e);
        p_rst    = rst;
        p_addr   = a;
        p_trans  = t;
        p_hready = e.hready;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest prediction
    always @(negedge hclk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("hsel",   {hsel_4, hsel_3, hsel_2, hsel_1}, e.hsel);
            chk("sel",    {2'b00, sel},                     {2'b00, e.sel});
            chk("hready", {3'b000, hready},                 {3'b000, e.hready});
            chk("hresp",  {3'b000, hresp},                  {3'b000, e.hresp});
        end
    end

    initial begin
        logic [31:0] ra;
        logic [3:0]  nib;
        logic [1:0]  rt;
        hreset = 1'b1; haddr = 32'h1000_0000; htrans = HTRANS_IDLE;
        mux_hreadyout = 1'b1; mux_hresp = 1'b0;
        p_rst = 1'b1; p_addr = '0; p_trans = '0; p_hready = 1'b1;
        m_sel = 0; m_def = 0; m_err = 0;

        // Reset held for two cycles
        step(32'h1000_0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b1);
        step(32'h1000_0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b1);
        step(32'h1000_0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
        // Mapped pipeline
        step(32'h0000_0010, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h3000_0004, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        // Wait states on slave-3 data phase while address targets slave 4
        step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h3000_0000, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0);
        step(32'h3000_0000, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0);
        step(32'h3000_0000, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0);
        step(32'h3000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0000, HTRANS_IDLE,   1'b1, 1'b0, 1'b0);
        // Unmapped NONSEQ: ERROR pair, then mapped transfer
        step(32'h8000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0000, HTRANS_IDLE,   1'b1, 1'b0, 1'b0);
        step(32'h0000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h1000_0000, HTRANS_IDLE,   1'b1, 1'b0, 1'b0);
        // Unmapped IDLE: zero-wait OKAY
        step(32'hF000_0000, HTRANS_IDLE,   1'b0, 1'b1, 1'b0);
        step(32'h0000_0000, HTRANS_IDLE,   1'b0, 1'b1, 1'b0);
        step(32'h0000_0000, HTRANS_IDLE,   1'b1, 1'b0, 1'b0);
        // New unmapped transfer issued in ERR2
        step(32'h9000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h9000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'hA000_0000, HTRANS_SEQ,    1'b1, 1'b0, 1'b0);
        step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0000, HTRANS_IDLE,   1'b1, 1'b0, 1'b0);
        // Reset during ERR1
        step(32'h3000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'hC000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0000, HTRANS_IDLE,   1'b1, 1'b1, 1'b1);
        step(32'h0000_0000, HTRANS_IDLE,   1'b0, 1'b1, 1'b0);
        step(32'h0000_0000, HTRANS_IDLE,   1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ra  = $urandom;
            nib = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) nib = 4'($urandom_range(8, 15));
            ra[31:28] = nib;
            rt = 2'($urandom_range(0, 3));
            step(ra, rt, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0));
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge hclk);
        @(negedge hclk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ahb_decoder
`default_nettype wire
